// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing, derived constants and coordinate type
package vga_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF  = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF  = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;
  localparam int HS_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
  localparam int VS_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

  // Inclusive window test, used for the active-low sync pulses.
  function automatic logic in_window(coord_t v, int lo, int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// rtl/scan_counter.sv - modulo counter with enable and wrap carry
// count_next exposes the value being loaded so callers can register decodes of it.
module scan_counter
  import vga_pkg::*;
#(
  parameter int MODULUS = H_TOTAL_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output coord_t count_next,
  output logic   carry
);

  localparam coord_t LAST = coord_t'(MODULUS - 1);

  coord_t count_q, count_d;

  always_comb begin
    carry   = en && (count_q == LAST);
    count_d = count_q;
    if (en) begin
      count_d = carry ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA raster scan generator with blanked DAC drive and frame tick
// Optional VGA_RGB_REG_EN: registered colour with sync/blank delayed one pixel to match.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       frame_start
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam coord_t H_VIS_C = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C = coord_t'(V_VISIBLE);

  logic   pix_en_q, pix_en_d;
  logic   hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic   frame_start_q, frame_start_d;
  coord_t hc, hc_next, vc, vc_next;
  logic   h_carry, v_carry;

  scan_counter #(.MODULUS(H_TOTAL)) u_h_cnt (
    .clk       (Clk),
    .rst       (Reset),
    .en        (pix_en_q),
    .count     (hc),
    .count_next(hc_next),
    .carry     (h_carry)
  );

  scan_counter #(.MODULUS(V_TOTAL)) u_v_cnt (
    .clk       (Clk),
    .rst       (Reset),
    .en        (h_carry),
    .count     (vc),
    .count_next(vc_next),
    .carry     (v_carry)
  );

  // Decode from the values being loaded so sync/blank land with DrawX/DrawY.
  always_comb begin
    pix_en_d      = ~pix_en_q;
    hs_d          = ~in_window(hc_next, HS_START, HS_END);
    vs_d          = ~in_window(vc_next, VS_START, VS_END);
    blank_n_d     = (hc_next < H_VIS_C) && (vc_next < V_VIS_C);
    frame_start_d = h_carry && !v_carry && (vc_next == V_VIS_C);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_en_q      <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_en_q      <= pix_en_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign DrawX       = hc;
  assign DrawY       = vc;
  assign VGA_CLK     = pix_en_q;
  assign VGA_SYNC_N  = 1'b0;
  assign frame_start = frame_start_q;

`ifdef VGA_RGB_REG_EN
  logic       hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d, blank_dly_q, blank_dly_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;

  // Capture on advance edges: colour of the pixel just shown, with its own sync/blank.
  always_comb begin
    hs_dly_d    = hs_dly_q;
    vs_dly_d    = vs_dly_q;
    blank_dly_d = blank_dly_q;
    r_d         = r_q;
    g_d         = g_q;
    b_d         = b_q;
    if (pix_en_q) begin
      hs_dly_d    = hs_q;
      vs_dly_d    = vs_q;
      blank_dly_d = blank_n_q;
      r_d         = blank_n_q ? Red_in   : 8'd0;
      g_d         = blank_n_q ? Green_in : 8'd0;
      b_d         = blank_n_q ? Blue_in  : 8'd0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_dly_q    <= 1'b1;
      vs_dly_q    <= 1'b1;
      blank_dly_q <= 1'b0;
      r_q         <= 8'd0;
      g_q         <= 8'd0;
      b_q         <= 8'd0;
    end else begin
      hs_dly_q    <= hs_dly_d;
      vs_dly_q    <= vs_dly_d;
      blank_dly_q <= blank_dly_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
    end
  end

  assign VGA_HS      = hs_dly_q;
  assign VGA_VS      = vs_dly_q;
  assign VGA_BLANK_N = blank_dly_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
`else
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_R       = blank_n_q ? Red_in   : 8'd0;
  assign VGA_G       = blank_n_q ? Green_in : 8'd0;
  assign VGA_B       = blank_n_q ? Blue_in  : 8'd0;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - bench for vga_scan_gen: default timing for line checks, shrunk timing for frame checks
module tb_vga_scan_gen;

  localparam int SH_VIS = 16, SH_FR = 4, SH_SY = 6, SH_BK = 4;
  localparam int SV_VIS = 10, SV_FR = 2, SV_SY = 2, SV_BK = 3;
  localparam int SH_TOT = SH_VIS + SH_FR + SH_SY + SH_BK;
  localparam int SV_TOT = SV_VIS + SV_FR + SV_SY + SV_BK;
  localparam int S_FRAME_CLK = 2 * SH_TOT * SV_TOT;
`ifdef VGA_RGB_REG_EN
  localparam int HS_LAG = 1;
`else
  localparam int HS_LAG = 0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] red_in = 8'hFF, green_in = 8'h3C, blue_in = 8'hC5;

  logic [9:0] d_x, d_y, s_x, s_y;
  logic       d_vclk, d_hs, d_vs, d_bl, d_sn, d_fs;
  logic       s_vclk, s_hs, s_vs, s_bl, s_sn, s_fs;
  logic [7:0] d_r, d_g, d_b, s_r, s_g, s_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  vga_scan_gen dut_d (
    .Clk(Clk), .Reset(Reset), .Red_in(red_in), .Green_in(green_in), .Blue_in(blue_in),
    .DrawX(d_x), .DrawY(d_y), .VGA_CLK(d_vclk), .VGA_HS(d_hs), .VGA_VS(d_vs),
    .VGA_BLANK_N(d_bl), .VGA_SYNC_N(d_sn), .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b),
    .frame_start(d_fs)
  );

  vga_scan_gen #(
    .H_VISIBLE(SH_VIS), .H_FRONT(SH_FR), .H_SYNC(SH_SY), .H_BACK(SH_BK),
    .V_VISIBLE(SV_VIS), .V_FRONT(SV_FR), .V_SYNC(SV_SY), .V_BACK(SV_BK)
  ) dut_s (
    .Clk(Clk), .Reset(Reset), .Red_in(red_in), .Green_in(green_in), .Blue_in(blue_in),
    .DrawX(s_x), .DrawY(s_y), .VGA_CLK(s_vclk), .VGA_HS(s_hs), .VGA_VS(s_vs),
    .VGA_BLANK_N(s_bl), .VGA_SYNC_N(s_sn), .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
    .frame_start(s_fs)
  );

  typedef struct {
    int         x;
    int         y;
    logic       vclk, hs, vs, bl, fs;
    logic [7:0] r, g;
  } exp_t;

  exp_t exp_q[$];
  int   k = 0;

  function automatic void pixel_flags(input int pp, output logic hs, output logic vs, output logic bl);
    int hc = pp % SH_TOT;
    int vc = (pp / SH_TOT) % SV_TOT;
    hs = !(hc >= SH_VIS + SH_FR && hc < SH_VIS + SH_FR + SH_SY);
    vs = !(vc >= SV_VIS + SV_FR && vc < SV_VIS + SV_FR + SV_SY);
    bl = (hc < SH_VIS) && (vc < SV_VIS);
  endfunction

  // Closed-form expectation for the shrunk instance: k = edges since reset released.
  always @(posedge Clk) begin
    exp_t e;
    int   p;
    logic hs, vs, bl;
    if (Reset) k = 0;
    else k = k + 1;
    p = k / 2;
    e.x = 0; e.y = 0; e.vclk = 1'b0; e.fs = 1'b0;
    hs = 1'b1; vs = 1'b1; bl = 1'b0;
    if (k > 0) begin
      e.x = p % SH_TOT;
      e.y = (p / SH_TOT) % SV_TOT;
      e.vclk = (k % 2) == 1;
      e.fs = ((k % 2) == 0) && (e.x == 0) && (e.y == SV_VIS);
`ifdef VGA_RGB_REG_EN
      if (p >= 1) pixel_flags(p - 1, hs, vs, bl);
`else
      pixel_flags(p, hs, vs, bl);
`endif
    end
    e.hs = hs; e.vs = vs; e.bl = bl;
    e.r = bl ? 8'hFF : 8'h00;
    e.g = bl ? 8'h3C : 8'h00;
    exp_q.push_back(e);
  end

  localparam logic [46:0] RST_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0};

  task automatic test_reset();
    logic [46:0] got;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    got = {d_x, d_y, d_vclk, d_hs, d_vs, d_bl, d_sn, d_fs, d_r, d_g, d_b};
    n_cmp++; if (got !== RST_VEC) begin n_bad++; $display("FAIL reset_default got %h want %h", got, RST_VEC); end
    got = {s_x, s_y, s_vclk, s_hs, s_vs, s_bl, s_sn, s_fs, s_r, s_g, s_b};
    n_cmp++; if (got !== RST_VEC) begin n_bad++; $display("FAIL reset_small got %h want %h", got, RST_VEC); end
  endtask

  task automatic test_startup();
    exp_t e;
    Reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (exp_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL startup_sb_empty got 0 want 1"); return; end
      e = exp_q.pop_front();
      n_cmp++; if (d_x !== 10'(e.x)) begin n_bad++; $display("FAIL startup_drawx cyc %0d got %0d want %0d", i, d_x, e.x); end
      n_cmp++; if (d_vclk !== e.vclk) begin n_bad++; $display("FAIL startup_vga_clk cyc %0d got %b want %b", i, d_vclk, e.vclk); end
      n_cmp++; if (d_bl !== e.bl) begin n_bad++; $display("FAIL startup_blank_n cyc %0d got %b want %b", i, d_bl, e.bl); end
    end
  endtask

  task automatic test_line();
    int   hs_cnt = 0, first_x = -1, y_after = -1, prev_x = -1;
    logic wrapped = 1'b0;
    for (int i = 0; i < 1700; i++) begin
      @(negedge Clk);
      if (!d_hs) begin
        if (hs_cnt == 0) first_x = int'(d_x);
        hs_cnt++;
      end
      if (prev_x == 799 && d_x == 10'd0) begin wrapped = 1'b1; y_after = int'(d_y); break; end
      prev_x = int'(d_x);
    end
    n_cmp++; if (!wrapped) begin n_bad++; $display("FAIL line_wrap_timeout got 0 want 1"); end
    n_cmp++; if (hs_cnt != 192) begin n_bad++; $display("FAIL line_hs_low_clks got %0d want 192", hs_cnt); end
    n_cmp++; if (first_x != 656 + HS_LAG) begin n_bad++; $display("FAIL line_hs_start_x got %0d want %0d", first_x, 656 + HS_LAG); end
    n_cmp++; if (y_after != 1) begin n_bad++; $display("FAIL line_drawy_inc got %0d want 1", y_after); end
  endtask

  task automatic test_frame();
    exp_t        e;
    logic [40:0] got, want;
    int          n_fs_dut = 0, n_fs_exp = 0, fs_first = -1, fs_second = -1, vs_low = 0;
    exp_q.delete();
    for (int i = 0; i < 2 * S_FRAME_CLK + 20; i++) begin
      @(negedge Clk);
      if (exp_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL frame_sb_empty got 0 want 1"); return; end
      e = exp_q.pop_front();
      got  = {s_x, s_y, s_vclk, s_hs, s_vs, s_bl, s_fs, s_r, s_g};
      want = {10'(e.x), 10'(e.y), e.vclk, e.hs, e.vs, e.bl, e.fs, e.r, e.g};
      n_cmp++; if (got !== want) begin n_bad++; $display("FAIL frame_sb cyc %0d got %h want %h", i, got, want); end
      if (e.fs) n_fs_exp++;
      if (s_fs) begin
        n_fs_dut++;
        n_cmp++; if (s_x !== 10'd0 || s_y !== 10'(SV_VIS)) begin n_bad++; $display("FAIL frame_start_pos got (%0d,%0d) want (0,%0d)", s_x, s_y, SV_VIS); end
        if (fs_first < 0) fs_first = i;
        else if (fs_second < 0) fs_second = i;
      end
      if (fs_first >= 0 && fs_second < 0 && !s_vs) vs_low++;
    end
    n_cmp++; if (n_fs_dut != n_fs_exp) begin n_bad++; $display("FAIL frame_start_count got %0d want %0d", n_fs_dut, n_fs_exp); end
    n_cmp++; if (fs_second - fs_first != S_FRAME_CLK) begin n_bad++; $display("FAIL frame_start_period got %0d want %0d", fs_second - fs_first, S_FRAME_CLK); end
    n_cmp++; if (vs_low != 2 * SV_SY * SH_TOT) begin n_bad++; $display("FAIL frame_vs_low_clks got %0d want %0d", vs_low, 2 * SV_SY * SH_TOT); end
  endtask

  task automatic test_reset_mid();
    exp_t        e;
    logic [46:0] got;
    logic [40:0] gs, ws;
    logic        found = 1'b0;
    int          fs_first = -1;
    for (int i = 0; i < S_FRAME_CLK + 100; i++) begin
      @(negedge Clk);
      if (s_x == 10'd10 && s_y == 10'd5) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL midreset_reach_timeout got 0 want 1"); end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    got = {d_x, d_y, d_vclk, d_hs, d_vs, d_bl, d_sn, d_fs, d_r, d_g, d_b};
    n_cmp++; if (got !== RST_VEC) begin n_bad++; $display("FAIL midreset_default got %h want %h", got, RST_VEC); end
    got = {s_x, s_y, s_vclk, s_hs, s_vs, s_bl, s_sn, s_fs, s_r, s_g, s_b};
    n_cmp++; if (got !== RST_VEC) begin n_bad++; $display("FAIL midreset_small got %h want %h", got, RST_VEC); end
    exp_q.delete();
    for (int i = 0; i < S_FRAME_CLK + 20; i++) begin
      @(negedge Clk);
      if (exp_q.size() == 0) begin n_cmp++; n_bad++; $display("FAIL midreset_sb_empty got 0 want 1"); return; end
      e = exp_q.pop_front();
      gs = {s_x, s_y, s_vclk, s_hs, s_vs, s_bl, s_fs, s_r, s_g};
      ws = {10'(e.x), 10'(e.y), e.vclk, e.hs, e.vs, e.bl, e.fs, e.r, e.g};
      n_cmp++; if (gs !== ws) begin n_bad++; $display("FAIL midreset_sb cyc %0d got %h want %h", i, gs, ws); end
      if (i == 3) begin
        n_cmp++; if (d_x !== 10'd2 || d_y !== 10'd0) begin n_bad++; $display("FAIL midreset_default_restart got (%0d,%0d) want (2,0)", d_x, d_y); end
      end
      if (s_fs && fs_first < 0) fs_first = i;
    end
    n_cmp++; if (fs_first != 2 * SV_VIS * SH_TOT - 1) begin n_bad++; $display("FAIL midreset_first_frame_start got %0d want %0d", fs_first, 2 * SV_VIS * SH_TOT - 1); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_line();
    test_frame();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
# vga_scan_gen

Raster scan generator for the 640x480@60 Hz display path. Produces the DrawX/DrawY pixel coordinates consumed by the colour mapper, and takes back the mapper's combinational Red/Green/Blue. Drives the VGA DAC pins (sync, blank, pixel clock, RGB) with blanking applied. Also issues a once-per-frame tick for the game-object position/bullet update logic.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports (clock and reset first):
- Clk  in  1  system clock, 50 MHz; the only clock
- Reset  in  1  synchronous, active-high reset
- Red_in, Green_in, Blue_in  in  8 each  colour for current DrawX/DrawY, from colour mapper
- DrawX  out  10  current horizontal position, 0..H_TOTAL-1
- DrawY  out  10  current vertical position, 0..V_TOTAL-1
- VGA_CLK  out  1  pixel clock, Clk/2
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK_N  out  1  low outside the visible area
- VGA_SYNC_N  out  1  constant 0
- VGA_R, VGA_G, VGA_B  out  8 each  DAC colour; 0 whenever blanked
- frame_start  out  1  one-Clk pulse at start of vertical blanking

## Operation
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Both must be ≤1024.
- pix_en toggles every Clk. VGA_CLK equals registered pix_en. Counters advance only on Clk edges where pix_en=1.
- hc counts 0..H_TOTAL-1. Wrap from H_TOTAL-1 to 0 increments vc. vc wraps V_TOTAL-1 to 0.
- DrawX=hc, DrawY=vc, both registered.
- VGA_HS=0 when hc in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656,751].
- VGA_VS=0 when vc in [490,491].
- VGA_BLANK_N=1 when hc<640 and vc<480.
- HS/VS/BLANK_N are registered from the next counter values on the same edge, so they are coherent with DrawX/DrawY.
- frame_start=1 for exactly one Clk, on the edge where vc becomes V_VISIBLE (480) with hc becoming 0.
- Reset (any cycle, including mid-line or mid-frame) forces on the next edge: hc=0, vc=0, pix_en=0, VGA_CLK=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0, frame_start=0. No frame_start is generated by reset.

## Timing
- One pixel = 2 Clk. Line = 1600 Clk. Frame = 840000 Clk.
- frame_start period is 840000 Clk.
- Without the macro: VGA_R/G/B = VGA_BLANK_N ? *_in : 0, combinational. Zero added latency.
- Colour inputs must settle within one Clk of a DrawX/DrawY change.

## Configuration
- VGA_RGB_REG_EN defined:
  - VGA_R/G/B are registered on pix_en edges.
  - VGA_HS, VGA_VS and VGA_BLANK_N are delayed one pixel (2 Clk) to stay aligned with the registered colour.
  - DrawX/DrawY and frame_start are unchanged.
  - Reset clears the delay registers to their idle values.
- Not defined: combinational RGB path as above, and no delay stage.

## Structure
- Package vga_pkg holds:
  - default timing constants;
  - derived H_TOTAL/V_TOTAL and the sync start/end localparams;
  - the 10-bit coordinate typedef.
- One sub-module is natural: scan_counter, a parameterised modulo counter with enable and wrap-carry output. It is instantiated twice: H, enabled by pix_en; and V, enabled by the H carry.

## Test plan
- Reset, then release, then run 4 Clk → DrawX steps 0 then 1 after the second pix_en edge; VGA_CLK toggles every Clk; VGA_BLANK_N=1 at (0,0) after the first update.
- Run one line → VGA_HS low for exactly 192 Clk, starting when DrawX=656; DrawY increments when DrawX wraps 799→0.
- Run a full frame → VGA_VS low only for DrawY 490..491 (3200 Clk); DrawX/DrawY=(0,0) again after 840000 Clk.
- frame_start → exactly one pulse per frame, coincident with DrawX=0/DrawY=480; consecutive pulses 840000 Clk apart.
- Red_in=FF everywhere → VGA_R=FF only when DrawX<640 and DrawY<480, else 00. With VGA_RGB_REG_EN, the same check holds against sync/blank delayed 2 Clk.
- Assert Reset at DrawX=300/DrawY=200 for 1 Clk → next edge shows all reset values; the scan restarts from (0,0); no spurious frame_start.
